vga_timing_ctrl: RTL and testbench

Source end of the pixel-coordinate interface. It drives the x/y coordinates consumed by the rectangle and sprite generators, and generates VGA hsync, vsync and blank. It also samples the generators' combinational RGB result, gates it with blank, and registers it so that colour and sync leave the FPGA aligned. It sits between the board clock and the VGA connector, with all pixel generators hanging off x/y.

---
 rtl/vga_timing_ctrl_pkg.sv | 22 ++
 rtl/vga_axis_counter.sv | 42 ++++
 rtl/vga_timing_ctrl.sv | 88 ++++++++
 tb/tb_vga_timing_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_ctrl_pkg.sv
// vga_timing_ctrl_pkg: 640x480@60 timing defaults, colour width and axis total helper
package vga_timing_ctrl_pkg;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP = 33;
    localparam int VGA_CLK_DIV = 2;
    localparam int COLOR_W = 4;
    localparam int X_W = 11;
    localparam int Y_W = 10;

    function automatic int axis_total(input int visible, input int fp, input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = axis_total(VGA_H_VISIBLE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = axis_total(VGA_V_VISIBLE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis; counts on en, wraps at the axis total, decodes visible and sync windows
module vga_axis_counter
    import vga_timing_ctrl_pkg::*;
#(
    parameter int VISIBLE = VGA_H_VISIBLE,
    parameter int FP = VGA_H_FP,
    parameter int SYNC = VGA_H_SYNC,
    parameter int BP = VGA_H_BP,
    parameter int WIDTH = X_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wrap_in,
    output logic [WIDTH-1:0] count,
    output logic             wrap_out,
    output logic             active,
    output logic             sync
);
    localparam int TOTAL = axis_total(VISIBLE, FP, SYNC, BP);
    localparam int SYNC_START = VISIBLE + FP;

    if (TOTAL > (1 << WIDTH)) begin : g_range
        $error("vga_axis_counter: axis total does not fit in WIDTH bits");
    end

    logic [31:0] c;
    logic last;

    assign c = 32'(count);
    assign last = c == TOTAL - 1;
    assign wrap_out = en && last;
    assign active = c < VISIBLE;
    assign sync = c >= SYNC_START && c < SYNC_START + SYNC;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (en)
            count <= (wrap_in || last) ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: pixel-enable divider, x/y counters, sync/blank decode and aligned output register
module vga_timing_ctrl
    import vga_timing_ctrl_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP = VGA_V_BP,
    parameter int CLK_DIV = VGA_CLK_DIV,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               pix_en,
    output logic               line_start,
    output logic               frame_start,
    input  logic [COLOR_W-1:0] red_in,
    input  logic [COLOR_W-1:0] green_in,
    input  logic [COLOR_W-1:0] blue_in,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               vga_blank
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_timing_ctrl: CLK_DIV must be at least 1");
    end

    logic [DW-1:0] div;
    logic h_wrap, h_active, h_sync, v_active, v_sync, frame_wrap_unused;
    logic blank_c, hs_c, vs_c;

    assign pix_en = 32'(div) == CLK_DIV - 1;
    assign line_start = pix_en && x == '0;
    assign frame_start = line_start && y == '0;
    assign blank_c = !(h_active && v_active);
    assign hs_c = h_sync ? SYNC_POL : ~SYNC_POL;
    assign vs_c = v_sync ? SYNC_POL : ~SYNC_POL;

    always_ff @(posedge clk) begin
        if (reset)
            div <= '0;
        else
            div <= pix_en ? '0 : div + 1'b1;
    end

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .WIDTH(X_W)
    ) u_h (
        .clk(clk), .reset(reset), .en(pix_en), .wrap_in(1'b0),
        .count(x), .wrap_out(h_wrap), .active(h_active), .sync(h_sync)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .WIDTH(Y_W)
    ) u_v (
        .clk(clk), .reset(reset), .en(h_wrap), .wrap_in(1'b0),
        .count(y), .wrap_out(frame_wrap_unused), .active(v_active), .sync(v_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
            vga_blank <= 1'b1;
            vga_hsync <= ~SYNC_POL;
            vga_vsync <= ~SYNC_POL;
        end else if (pix_en) begin
            vga_r <= blank_c ? '0 : red_in;
            vga_g <= blank_c ? '0 : green_in;
            vga_b <= blank_c ? '0 : blue_in;
            vga_blank <= blank_c;
            vga_hsync <= hs_c;
            vga_vsync <= vs_c;
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench; default horizontal timing, vertical shrunk to 9 lines per frame
module tb_vga_timing_ctrl;
    localparam int CLK_DIV = 2;
    localparam int H_VIS = 640, H_SS = 656, H_SE = 752, H_TOT = 800;
    localparam int V_VIS = 4, V_SS = 5, V_SE = 7, V_TOT = 9;

    typedef struct packed {
        logic [3:0] r, g, b;
        logic hs, vs, bl;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] red_in = 4'h0, green_in = 4'h0, blue_in = 4'h0;
    logic [10:0] x;
    logic [9:0] y;
    logic pix_en, line_start, frame_start;
    logic [3:0] vga_r, vga_g, vga_b;
    logic vga_hsync, vga_vsync, vga_blank;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int mdiv = 0, mx = 0, my = 0;
    bit m_rst = 1'b1;
    bit prev_pe = 1'b0;

    vga_timing_ctrl #(
        .V_VISIBLE(V_VIS), .V_FP(1), .V_SYNC(2), .V_BP(2), .CLK_DIV(CLK_DIV), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .pix_en(pix_en),
        .line_start(line_start), .frame_start(frame_start),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t make_exp(input int px, input int py, input logic [3:0] r,
                                      input logic [3:0] g, input logic [3:0] b);
        exp_t e;
        e.bl = px >= H_VIS || py >= V_VIS;
        e.r = e.bl ? 4'h0 : r;
        e.g = e.bl ? 4'h0 : g;
        e.b = e.bl ? 4'h0 : b;
        e.hs = !(px >= H_SS && px < H_SE);
        e.vs = !(py >= V_SS && py < V_SE);
        return e;
    endfunction

    always @(posedge clk) begin
        m_rst <= reset;
        if (reset) begin
            mdiv <= 0;
            mx <= 0;
            my <= 0;
            sb.delete();
        end else begin
            if (mdiv == CLK_DIV - 1) begin
                sb.push_back(make_exp(mx, my, red_in, green_in, blue_in));
                mx <= (mx == H_TOT - 1) ? 0 : mx + 1;
                if (mx == H_TOT - 1)
                    my <= (my == V_TOT - 1) ? 0 : my + 1;
            end
            mdiv <= (mdiv == CLK_DIV - 1) ? 0 : mdiv + 1;
        end
    end

    always @(negedge clk) begin
        if (m_rst) begin
            chk("rst_r", vga_r, 0);
            chk("rst_g", vga_g, 0);
            chk("rst_b", vga_b, 0);
            chk("rst_blank", vga_blank, 1);
            chk("rst_hsync", vga_hsync, 1);
            chk("rst_vsync", vga_vsync, 1);
        end else if (prev_pe) begin
            chk("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                chk("out_r", vga_r, sb[0].r);
                chk("out_g", vga_g, sb[0].g);
                chk("out_b", vga_b, sb[0].b);
                chk("out_hsync", vga_hsync, sb[0].hs);
                chk("out_vsync", vga_vsync, sb[0].vs);
                chk("out_blank", vga_blank, sb[0].bl);
                void'(sb.pop_front());
            end
        end
        chk("x", x, mx);
        chk("y", y, my);
        chk("pix_en", pix_en, mdiv == CLK_DIV - 1);
        chk("line_start", line_start, mdiv == CLK_DIV - 1 && mx == 0);
        chk("frame_start", frame_start, mdiv == CLK_DIV - 1 && mx == 0 && my == 0);
        prev_pe <= pix_en;
    end

    initial begin
        int n, lines, first_ls, hs_low, vs_low, lit;
        red_in = 4'hF;
        green_in = 4'hF;
        blue_in = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (x == 0 && n < 10);
        chk("x_first_step_clks", n, 2);
        chk("x_first_step_val", x, 1);
        n = 0;
        while (!frame_start && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_start_found", frame_start, 1);
        n = 0;
        lines = 0;
        first_ls = 0;
        hs_low = 0;
        vs_low = 0;
        lit = 0;
        do begin
            @(negedge clk);
            n++;
            if (line_start) begin
                lines++;
                if (first_ls == 0) begin
                    first_ls = n;
                    chk("y_after_first_line", y, 1);
                end
            end
            if (n <= 1600 && !vga_hsync) hs_low++;
            if (!vga_vsync) vs_low++;
            if (vga_r == 4'hF) lit++;
        end while (!frame_start && n < 20000);
        chk("frame_period_clks", n, 14400);
        chk("line_starts_per_frame", lines, 9);
        chk("line_period_clks", first_ls, 1600);
        chk("hsync_low_clks", hs_low, 192);
        chk("vsync_low_clks", vs_low, 3200);
        chk("lit_red_clks", lit, 5120);
        n = 0;
        while (!(pix_en && x == 700 && y == 3) && n < 20000) begin
            @(negedge clk);
            n++;
            red_in = 4'(n);
            green_in = 4'(n * 7);
            blue_in = 4'(n >> 3);
        end
        chk("trigger_x", x, 700);
        chk("trigger_y", y, 3);
        chk("hsync_low_before_reset", vga_hsync, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("hsync_inactive_reset_clk", vga_hsync, 1);
        chk("x_in_reset", x, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("y_in_reset", y, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 10);
        chk("frame_start_after_reset_clks", n, 1);
        repeat (40) @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
